// File: rtl/lc_line_memory.sv
// lc_line_memory: lower-cache line store with an in-order request FIFO and a fixed service latency
module lc_line_memory #(
   parameter int B           = 64,
   parameter int PADDR_BITS  = 19,
   parameter int MEM_LINES   = 256,
   parameter int LATENCY     = 8,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_N_in,
   input  logic                  cs_N_in,
   input  logic                  l1d_valid_in,
   input  logic                  l1d_we_in,
   input  logic [PADDR_BITS-1:0] l1d_addr_in,
   input  logic [8*B-1:0]        l1d_value_in,
   input  logic                  l1d_ready_in,
   output logic                  l1d_ready_out,
   output logic                  l1d_valid_out,
   output logic [PADDR_BITS-1:0] l1d_addr_out,
   output logic [8*B-1:0]        l1d_value_out
);
   localparam int OFF  = $clog2(B);
   localparam int LIDX = $clog2(MEM_LINES);
   localparam int PW   = $clog2(QUEUE_DEPTH);
   localparam int CW   = $clog2(LATENCY + 1);
   localparam int W    = 8 * B;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                  cur_we_q, cur_we_d;
   logic [PADDR_BITS-1:0] cur_addr_q, cur_addr_d, resp_addr_q, resp_addr_d;
   logic [W-1:0]          cur_data_q, cur_data_d, resp_data_q, resp_data_d;
   logic                  fifo_we_q [QUEUE_DEPTH];
   logic [PADDR_BITS-1:0] fifo_addr_q [QUEUE_DEPTH];
   logic [W-1:0]          fifo_data_q [QUEUE_DEPTH];
   logic [W-1:0]          mem_q [MEM_LINES] = '{default: '0};
   logic [PADDR_BITS-1:0] line_addr;
   logic                  full, empty, push, mem_we;

   assign empty         = wr_ptr_q == rd_ptr_q;
   assign full          = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign l1d_ready_out = !full && !cs_N_in && rst_N_in;
   assign push          = l1d_valid_in && l1d_ready_out;
   assign line_addr     = l1d_addr_in & ~PADDR_BITS'(B - 1);
   assign l1d_valid_out = state_q == RESP;
   assign l1d_addr_out  = resp_addr_q;
   assign l1d_value_out = resp_data_q;

   // Sequencer: pop one request, count down its latency, then commit a write or present a read fill.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_ptr_d    = rd_ptr_q;
      cur_we_d    = cur_we_q;
      cur_addr_d  = cur_addr_q;
      cur_data_d  = cur_data_q;
      resp_addr_d = resp_addr_q;
      resp_data_d = resp_data_q;
      mem_we      = 1'b0;
      wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      if (!cs_N_in) begin
         case (state_q)
            IDLE: if (!empty) begin
               rd_ptr_d   = rd_ptr_q + 1'b1;
               cur_we_d   = fifo_we_q[rd_ptr_q[PW-1:0]];
               cur_addr_d = fifo_addr_q[rd_ptr_q[PW-1:0]];
               cur_data_d = fifo_data_q[rd_ptr_q[PW-1:0]];
               cnt_d      = CW'(LATENCY - 1);
               state_d    = BUSY;
            end
            BUSY: if (cnt_q == CW'(1)) begin
               cnt_d = '0;
               if (cur_we_q) begin
                  mem_we  = 1'b1;
                  state_d = IDLE;
               end else begin
                  resp_addr_d = cur_addr_q;
                  resp_data_d = mem_q[cur_addr_q[OFF +: LIDX]];
                  state_d     = RESP;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
            RESP: state_d = l1d_ready_in ? IDLE : RESP;
            default: state_d = IDLE;
         endcase
      end
   end

   // Control, in-service request and response registers; reset drops all pending work.
   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cur_we_q    <= 1'b0;
         cur_addr_q  <= '0;
         cur_data_q  <= '0;
         resp_addr_q <= '0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cur_we_q    <= cur_we_d;
         cur_addr_q  <= cur_addr_d;
         cur_data_q  <= cur_data_d;
         resp_addr_q <= resp_addr_d;
         resp_data_q <= resp_data_d;
      end
   end

   // Request FIFO payload; pointers alone decide which slots are live.
   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_we_q[wr_ptr_q[PW-1:0]]   <= l1d_we_in;
         fifo_addr_q[wr_ptr_q[PW-1:0]] <= line_addr;
         fifo_data_q[wr_ptr_q[PW-1:0]] <= l1d_value_in;
      end
   end

   // Backing storage; survives reset and aliases on the low line-index bits.
   always_ff @(posedge clk_in) begin
      if (mem_we) mem_q[cur_addr_q[OFF +: LIDX]] <= cur_data_q;
   end
endmodule

// File: tb/tb_lc_line_memory.sv
// tb_lc_line_memory: vector table, corner sequences and randomized scoreboard for lc_line_memory
module tb_lc_line_memory;
   localparam int B  = 64;
   localparam int W  = 8 * B;
   localparam int PA = 19;
   localparam int L  = 8;
   localparam int QD = 4;

   typedef struct {
      logic          we;
      logic [PA-1:0] addr;
      logic [7:0]    fill;
      logic [PA-1:0] exp_addr;
      logic [7:0]    exp_fill;
   } vec_t;

   typedef struct {
      logic [PA-1:0] a;
      logic [W-1:0]  d;
   } resp_t;

   logic          clk_in = 1'b0;
   logic          rst_N_in = 1'b1;
   logic          cs_N_in = 1'b0;
   logic          l1d_valid_in = 1'b0;
   logic          l1d_we_in = 1'b0;
   logic [PA-1:0] l1d_addr_in = '0;
   logic [W-1:0]  l1d_value_in = '0;
   logic          l1d_ready_in = 1'b1;
   logic          l1d_ready_out, l1d_valid_out;
   logic [PA-1:0] l1d_addr_out;
   logic [W-1:0]  l1d_value_out;
   int            n_chk = 0;
   int            n_pass = 0;
   int            cyc = 0;

   lc_line_memory #(.B(B), .PADDR_BITS(PA), .MEM_LINES(256), .LATENCY(L), .QUEUE_DEPTH(QD)) dut (
      .clk_in(clk_in), .rst_N_in(rst_N_in), .cs_N_in(cs_N_in),
      .l1d_valid_in(l1d_valid_in), .l1d_we_in(l1d_we_in), .l1d_addr_in(l1d_addr_in),
      .l1d_value_in(l1d_value_in), .l1d_ready_in(l1d_ready_in), .l1d_ready_out(l1d_ready_out),
      .l1d_valid_out(l1d_valid_out), .l1d_addr_out(l1d_addr_out), .l1d_value_out(l1d_value_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #600000;
      $display("FAIL watchdog: got no completion, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   task automatic send(input logic we, input logic [PA-1:0] a, input logic [W-1:0] d);
      int n = 0;
      l1d_valid_in = 1'b1;
      l1d_we_in    = we;
      l1d_addr_in  = a;
      l1d_value_in = d;
      #1;
      while (!l1d_ready_out && n < 50) begin
         tick();
         n++;
      end
      chk("accept", W'(n < 50), W'(1));
      tick();
      l1d_valid_in = 1'b0;
   endtask

   task automatic wait_valid(input int k0, output int k);
      k = k0;
      while (!l1d_valid_out && k < k0 + 60) begin
         tick();
         k++;
      end
      chk("valid_seen", W'(l1d_valid_out), W'(1));
   endtask

   task automatic xact(input vec_t v);
      int k;
      send(v.we, v.addr, {B{v.fill}});
      if (v.we) repeat (L) tick();
      else begin
         wait_valid(0, k);
         chk("latency", W'(k), W'(L));
         chk("resp_addr", W'(l1d_addr_out), W'(v.exp_addr));
         chk("resp_value", l1d_value_out, {B{v.exp_fill}});
         tick();
         chk("valid_drop", W'(l1d_valid_out), W'(0));
      end
   endtask

   function automatic logic [W-1:0] rnd_line();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   initial begin
      vec_t          tbl [9];
      logic [PA-1:0] q5_addr [5];
      logic [7:0]    q5_fill [5];
      logic [W-1:0]  ref_mem [8];
      resp_t         exp_q [$];
      resp_t         e;
      logic          hold, hs;
      logic [PA-1:0] h_a;
      logic [W-1:0]  h_v;
      logic [4:0]    hi;
      logic [2:0]    li;
      int            k, t, tp, n;
      tbl[0] = '{1'b1, 19'h00040, 8'hA5, 19'h00000, 8'h00};
      tbl[1] = '{1'b0, 19'h00058, 8'h00, 19'h00040, 8'hA5};
      tbl[2] = '{1'b1, 19'h00000, 8'h3C, 19'h00000, 8'h00};
      tbl[3] = '{1'b0, 19'h04000, 8'h00, 19'h04000, 8'h3C};
      tbl[4] = '{1'b1, 19'h0007F, 8'h11, 19'h00000, 8'h00};
      tbl[5] = '{1'b0, 19'h00041, 8'h00, 19'h00040, 8'h11};
      tbl[6] = '{1'b1, 19'h12345, 8'h5A, 19'h00000, 8'h00};
      tbl[7] = '{1'b0, 19'h1234F, 8'h00, 19'h12340, 8'h5A};
      tbl[8] = '{1'b0, 19'h02340, 8'h00, 19'h02340, 8'h5A};
      q5_addr = '{19'h00040, 19'h00000, 19'h12340, 19'h7FFC0, 19'h04000};
      q5_fill = '{8'h11, 8'h3C, 8'h5A, 8'h00, 8'h3C};

      #2 rst_N_in = 1'b0;
      repeat (3) tick();
      chk("rst_valid", W'(l1d_valid_out), W'(0));
      chk("rst_addr", W'(l1d_addr_out), W'(0));
      chk("rst_value", l1d_value_out, W'(0));
      chk("rst_ready", W'(l1d_ready_out), W'(0));
      rst_N_in = 1'b1;
      #1;
      chk("post_rst_ready", W'(l1d_ready_out), W'(1));
      tick();

      for (int i = 0; i < 9; i++) xact(tbl[i]);

      l1d_ready_in = 1'b0;
      send(1'b0, 19'h7FFC0, '0);
      wait_valid(0, k);
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", W'(l1d_valid_out), W'(1));
         chk("hold_addr", W'(l1d_addr_out), W'(19'h7FFC0));
         chk("hold_value", l1d_value_out, W'(0));
         tick();
      end
      l1d_ready_in = 1'b1;
      tick();
      chk("hold_release", W'(l1d_valid_out), W'(0));
      repeat (L + 3) tick();
      chk("single_handshake", W'(l1d_valid_out), W'(0));

      l1d_ready_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         l1d_valid_in = 1'b1;
         l1d_we_in    = 1'b0;
         l1d_addr_in  = q5_addr[i];
         #1;
         chk("q_ready", W'(l1d_ready_out), W'(1));
         tick();
      end
      l1d_valid_in = 1'b0;
      #1;
      chk("q_full", W'(l1d_ready_out), W'(0));
      l1d_ready_in = 1'b1;
      tp = 0;
      for (int i = 0; i < 5; i++) begin
         wait_valid(0, k);
         t = cyc;
         if (i > 0) chk("q_gap", W'(t - tp), W'(L + 1));
         tp = t;
         chk("q_addr", W'(l1d_addr_out), W'(q5_addr[i]));
         chk("q_value", l1d_value_out, {B{q5_fill[i]}});
         tick();
      end

      l1d_ready_in = 1'b0;
      send(1'b0, 19'h12340, '0);
      tick();
      tick();
      cs_N_in      = 1'b1;
      l1d_valid_in = 1'b1;
      l1d_we_in    = 1'b1;
      l1d_addr_in  = 19'h00C00;
      l1d_value_in = {B{8'hEE}};
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("cs_no_accept", W'(l1d_ready_out), W'(0));
         tick();
      end
      cs_N_in      = 1'b0;
      l1d_valid_in = 1'b0;
      wait_valid(5, k);
      chk("cs_latency", W'(k), W'(L + 3));
      chk("cs_addr", W'(l1d_addr_out), W'(19'h12340));
      chk("cs_value", l1d_value_out, {B{8'h5A}});
      cs_N_in      = 1'b1;
      l1d_ready_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("cs_resp_hold", W'(l1d_valid_out), W'(1));
      end
      cs_N_in = 1'b0;
      tick();
      chk("cs_resp_release", W'(l1d_valid_out), W'(0));
      xact('{1'b0, 19'h00C00, 8'h00, 19'h00C00, 8'h00});

      send(1'b1, 19'h00100, {B{8'h77}});
      send(1'b0, 19'h00040, '0);
      tick();
      rst_N_in = 1'b0;
      #1;
      chk("mid_rst_ready", W'(l1d_ready_out), W'(0));
      chk("mid_rst_addr", W'(l1d_addr_out), W'(0));
      tick();
      tick();
      rst_N_in = 1'b1;
      #1;
      chk("mid_rst_release", W'(l1d_ready_out), W'(1));
      repeat (L + 3) tick();
      chk("mid_rst_discard", W'(l1d_valid_out), W'(0));
      xact('{1'b0, 19'h00100, 8'h00, 19'h00100, 8'h00});

      for (int i = 0; i < 8; i++) ref_mem[i] = '0;
      hold = 1'b0;
      h_a  = '0;
      h_v  = '0;
      for (int c = 0; c < 600; c++) begin
         hi = 5'($urandom());
         li = 3'($urandom());
         l1d_valid_in = $urandom_range(0, 99) < 60;
         l1d_we_in    = 1'($urandom());
         l1d_addr_in  = {hi, 5'b00010, li, 6'($urandom())};
         l1d_value_in = rnd_line();
         l1d_ready_in = $urandom_range(0, 99) < 70;
         cs_N_in      = $urandom_range(0, 99) < 10;
         #1;
         if (hold) begin
            chk("rnd_hold_valid", W'(l1d_valid_out), W'(1));
            chk("rnd_hold_addr", W'(l1d_addr_out), W'(h_a));
            chk("rnd_hold_value", l1d_value_out, h_v);
         end
         hs = l1d_valid_out && l1d_ready_in && !cs_N_in;
         if (hs) begin
            chk("rnd_expected", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("rnd_addr", W'(l1d_addr_out), W'(e.a));
               chk("rnd_value", l1d_value_out, e.d);
            end
         end
         if (l1d_valid_in && l1d_ready_out) begin
            if (l1d_we_in) ref_mem[li] = l1d_value_in;
            else exp_q.push_back('{{hi, 5'b00010, li, 6'b0}, ref_mem[li]});
         end
         hold = l1d_valid_out && !hs;
         h_a  = l1d_addr_out;
         h_v  = l1d_value_out;
         tick();
      end
      l1d_valid_in = 1'b0;
      cs_N_in      = 1'b0;
      l1d_ready_in = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         #1;
         if (l1d_valid_out) begin
            e = exp_q.pop_front();
            chk("drain_addr", W'(l1d_addr_out), W'(e.a));
            chk("drain_value", l1d_value_out, e.d);
         end
         tick();
         n++;
      end
      chk("drain_empty", W'(exp_q.size()), W'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
